demux_14_buf: RTL and testbench

- Registered 1-to-4 demultiplexer: the distribution counterpart of the pipeline's 2:1/4:1 select muxes.
- Accepts one data word per cycle on a valid/ready input and routes it by a 2-bit select into one of four single-entry output buffers.
- Each output drains independently through its own valid/ready handshake.
- Used in the 6-stage IITB RISC pipeline to steer a result word to one of four consumers (e.g. writeback, forwarding, flag, debug paths) without combinational input-to-output paths.

---
 rtl/iitb_risc_pkg.sv | 17 +
 rtl/demux_slot.sv | 51 +++++
 rtl/demux_14_buf.sv | 110 +++++++++++
 tb/tb_demux_14_buf.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/iitb_risc_pkg.sv
// Shared IITB RISC pipeline definitions: word/select widths, slot state and demux selects.
package iitb_risc_pkg;

   localparam int unsigned WORD_WIDTH      = 16;
   localparam int unsigned DEMUX_SEL_WIDTH = 2;

   typedef enum logic [0:0] {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   localparam logic [DEMUX_SEL_WIDTH-1:0] SEL_A = 2'd0;
   localparam logic [DEMUX_SEL_WIDTH-1:0] SEL_B = 2'd1;
   localparam logic [DEMUX_SEL_WIDTH-1:0] SEL_C = 2'd2;
   localparam logic [DEMUX_SEL_WIDTH-1:0] SEL_D = 2'd3;

endpackage

// File: rtl/demux_slot.sv
// Single-entry output buffer of the 1:4 demux: load, drain, synchronous flush.
module demux_slot
   import iitb_risc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = WORD_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  drain,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data
);

   slot_state_t           state_q, state_d;
   logic [DATA_WIDTH-1:0] data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SLOT_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Load wins over drain so a same-cycle drain+refill keeps the slot full.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = SLOT_EMPTY;
      end else if (load) begin
         state_d = SLOT_FULL;
      end else if ((state_q == SLOT_FULL) && drain) begin
         state_d = SLOT_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else if (load && !flush) begin
         data_q <= load_data;
      end
   end

   assign valid = (state_q == SLOT_FULL);
   assign data  = data_q;

endmodule

// File: rtl/demux_14_buf.sv
// Registered 1:4 demux with per-output single-entry buffers and valid/ready handshakes.
// Optional per-output handshake counters are enabled by defining DEMUX_14_PERF_CNT_EN.
module demux_14_buf
   import iitb_risc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = WORD_WIDTH,
   parameter int unsigned SEL_WIDTH  = DEMUX_SEL_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SEL_WIDTH-1:0]  in_sel,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid_a,
   output logic                  out_valid_b,
   output logic                  out_valid_c,
   output logic                  out_valid_d,
   input  logic                  out_ready_a,
   input  logic                  out_ready_b,
   input  logic                  out_ready_c,
   input  logic                  out_ready_d,
   output logic [DATA_WIDTH-1:0] out_data_a,
   output logic [DATA_WIDTH-1:0] out_data_b,
   output logic [DATA_WIDTH-1:0] out_data_c,
`ifdef DEMUX_14_PERF_CNT_EN
   output logic [DATA_WIDTH-1:0] out_data_d,
   output logic [15:0]           cnt_a,
   output logic [15:0]           cnt_b,
   output logic [15:0]           cnt_c,
   output logic [15:0]           cnt_d
`else
   output logic [DATA_WIDTH-1:0] out_data_d
`endif
);

   logic [3:0]            ready_vec;
   logic [3:0]            valid_vec;
   logic [3:0]            free_vec;
   logic [3:0]            load_vec;
   logic [DATA_WIDTH-1:0] data_vec [4];

   assign ready_vec[SEL_A] = out_ready_a;
   assign ready_vec[SEL_B] = out_ready_b;
   assign ready_vec[SEL_C] = out_ready_c;
   assign ready_vec[SEL_D] = out_ready_d;

   // A full slot is free when its consumer drains it this cycle.
   assign free_vec = ~valid_vec | ready_vec;

   always_comb begin
      in_ready = ~rst & ~flush & free_vec[in_sel];
      load_vec = '0;
      if (in_valid && in_ready) begin
         load_vec[in_sel] = 1'b1;
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_slot
      demux_slot #(
         .DATA_WIDTH(DATA_WIDTH)
      ) u_slot (
         .clk       (clk),
         .rst       (rst),
         .flush     (flush),
         .load      (load_vec[i]),
         .load_data (in_data),
         .drain     (ready_vec[i]),
         .valid     (valid_vec[i]),
         .data      (data_vec[i])
      );
   end

   assign out_valid_a = valid_vec[SEL_A];
   assign out_valid_b = valid_vec[SEL_B];
   assign out_valid_c = valid_vec[SEL_C];
   assign out_valid_d = valid_vec[SEL_D];
   assign out_data_a  = data_vec[SEL_A];
   assign out_data_b  = data_vec[SEL_B];
   assign out_data_c  = data_vec[SEL_C];
   assign out_data_d  = data_vec[SEL_D];

`ifdef DEMUX_14_PERF_CNT_EN
   logic [15:0] cnt_q [4];
   logic [3:0]  hs_vec;

   assign hs_vec = valid_vec & ready_vec;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (flush) begin
               cnt_q[i] <= '0;
            end else if (hs_vec[i] && (cnt_q[i] != 16'hFFFF)) begin
               cnt_q[i] <= cnt_q[i] + 16'd1;
            end
         end
      end
   end

   assign cnt_a = cnt_q[SEL_A];
   assign cnt_b = cnt_q[SEL_B];
   assign cnt_c = cnt_q[SEL_C];
   assign cnt_d = cnt_q[SEL_D];
`endif

endmodule

// File: tb/tb_demux_14_buf.sv
// Directed self-checking bench for demux_14_buf.
module tb_demux_14_buf;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_sel;
   logic [15:0] in_data;
   logic        out_valid_a, out_valid_b, out_valid_c, out_valid_d;
   logic        out_ready_a, out_ready_b, out_ready_c, out_ready_d;
   logic [15:0] out_data_a, out_data_b, out_data_c, out_data_d;
`ifdef DEMUX_14_PERF_CNT_EN
   logic [15:0] cnt_a, cnt_b, cnt_c, cnt_d;
`endif

   int checks = 0;
   int errors = 0;
   int hs_b   = 0;
   int base_b;

   always #5 clk = ~clk;

   demux_14_buf dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_sel      (in_sel),
      .in_data     (in_data),
      .out_valid_a (out_valid_a),
      .out_valid_b (out_valid_b),
      .out_valid_c (out_valid_c),
      .out_valid_d (out_valid_d),
      .out_ready_a (out_ready_a),
      .out_ready_b (out_ready_b),
      .out_ready_c (out_ready_c),
      .out_ready_d (out_ready_d),
      .out_data_a  (out_data_a),
      .out_data_b  (out_data_b),
      .out_data_c  (out_data_c),
`ifdef DEMUX_14_PERF_CNT_EN
      .out_data_d  (out_data_d),
      .cnt_a       (cnt_a),
      .cnt_b       (cnt_b),
      .cnt_c       (cnt_c),
      .cnt_d       (cnt_d)
`else
      .out_data_d  (out_data_d)
`endif
   );

   always @(posedge clk) begin
      if (!rst && out_valid_b && out_ready_b) hs_b <= hs_b + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] sel, input logic [15:0] d);
      in_valid = 1'b1;
      in_sel   = sel;
      in_data  = d;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0;
      in_valid = 1'b1; in_sel = 2'd0; in_data = 16'hDEAD;
      out_ready_a = 1'b0; out_ready_b = 1'b0; out_ready_c = 1'b0; out_ready_d = 1'b0;
      #3;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_valids", {28'd0, out_valid_a, out_valid_b, out_valid_c, out_valid_d}, 32'd0);
      chk("rst_data_ab", {out_data_a, out_data_b}, 32'd0);
      chk("rst_data_cd", {out_data_c, out_data_d}, 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      step();

      // Route one word to each output, all consumers stalled.
      send(2'd0, 16'h1111); #1;
      chk("route_a_ready", {31'd0, in_ready}, 32'd1);
      chk("route_a_pre", {31'd0, out_valid_a}, 32'd0);
      step();
      chk("route_a_valid", {15'd0, out_valid_a, out_data_a}, {15'd0, 1'b1, 16'h1111});
      chk("route_a_b_empty", {31'd0, out_valid_b}, 32'd0);
      send(2'd1, 16'h2222); step();
      chk("route_b_valid", {15'd0, out_valid_b, out_data_b}, {15'd0, 1'b1, 16'h2222});
      chk("route_b_c_empty", {31'd0, out_valid_c}, 32'd0);
      send(2'd2, 16'h3333); step();
      chk("route_c_valid", {15'd0, out_valid_c, out_data_c}, {15'd0, 1'b1, 16'h3333});
      send(2'd3, 16'h4444); step();
      chk("route_d_valid", {15'd0, out_valid_d, out_data_d}, {15'd0, 1'b1, 16'h4444});
      send(2'd2, 16'h5555); #1;
      chk("fifth_blocked", {31'd0, in_ready}, 32'd0);
      step();
      chk("fifth_c_held", {15'd0, out_valid_c, out_data_c}, {15'd0, 1'b1, 16'h3333});
      chk("fifth_a_held", {out_data_a}, 32'h1111);

      // Mid-cycle reset clears everything without waiting for an edge.
      in_valid = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("midrst_valids", {28'd0, out_valid_a, out_valid_b, out_valid_c, out_valid_d}, 32'd0);
      chk("midrst_data", {out_data_a ^ out_data_b ^ out_data_c ^ out_data_d}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      #1 rst = 1'b0;
      in_valid = 1'b0;
      step();

      // Drain and refill of slot B in one cycle.
      send(2'd1, 16'hAAAA); step();
      chk("b_loaded", {15'd0, out_valid_b, out_data_b}, {15'd0, 1'b1, 16'hAAAA});
      base_b = hs_b;
      out_ready_b = 1'b1;
      send(2'd1, 16'hBBBB); #1;
      chk("refill_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      chk("refill_b", {15'd0, out_valid_b, out_data_b}, {15'd0, 1'b1, 16'hBBBB});
      in_valid = 1'b0;
      step();
      chk("drain_b_empty", {15'd0, out_valid_b, out_data_b}, {15'd0, 1'b0, 16'hBBBB});
      chk("b_handshakes", hs_b - base_b, 32'd2);
      out_ready_b = 1'b0;
`ifdef DEMUX_14_PERF_CNT_EN
      chk("cnt_b_two", {16'd0, cnt_b}, 32'd2);
      chk("cnt_a_zero", {16'd0, cnt_a}, 32'd0);
`endif

      // A stalled must not block C.
      send(2'd0, 16'h0A0A); step();
      send(2'd0, 16'h1234); #1;
      chk("stall_a_blocked", {31'd0, in_ready}, 32'd0);
      send(2'd2, 16'h0C0C); #1;
      chk("stall_c_ready", {31'd0, in_ready}, 32'd1);
      step();
      chk("stall_c_loaded", {15'd0, out_valid_c, out_data_c}, {15'd0, 1'b1, 16'h0C0C});
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("stall_a_stable", {15'd0, out_valid_a, out_data_a}, {15'd0, 1'b1, 16'h0A0A});
      end

      // Flush beats accept and drain.
      send(2'd1, 16'h0B0B); step();
      send(2'd3, 16'h0D0D); step();
      chk("all_full", {28'd0, out_valid_a, out_valid_b, out_valid_c, out_valid_d}, 32'hF);
      flush = 1'b1; out_ready_a = 1'b1;
      send(2'd1, 16'hFFFF); #1;
      chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      chk("flush_valids", {28'd0, out_valid_a, out_valid_b, out_valid_c, out_valid_d}, 32'd0);
      flush = 1'b0; out_ready_a = 1'b0; in_valid = 1'b0;
`ifdef DEMUX_14_PERF_CNT_EN
      chk("flush_cnts", {cnt_a | cnt_b | cnt_c | cnt_d}, 32'd0);
`endif

      // Ready on empty slots is ignored.
      out_ready_a = 1'b1; out_ready_b = 1'b1; out_ready_c = 1'b1; out_ready_d = 1'b1;
      step();
      chk("empty_ready_ignored", {28'd0, out_valid_a, out_valid_b, out_valid_c, out_valid_d},
          32'd0);
      out_ready_a = 1'b0; out_ready_b = 1'b0; out_ready_c = 1'b0;

`ifdef DEMUX_14_PERF_CNT_EN
      // Back-to-back drain+refill on D until the counter saturates.
      send(2'd3, 16'h7777);
      repeat (65541) @(posedge clk);
      #1;
      chk("cnt_d_sat", {16'd0, cnt_d}, 32'h0000FFFF);
      step();
      chk("cnt_d_no_wrap", {16'd0, cnt_d}, 32'h0000FFFF);
      in_valid = 1'b0;
`endif
      out_ready_d = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
